// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between the SPI loader, the execute core and
// the display viewer using registered, one-beat grants with a bounded loader lock.
module dcache_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_req_in,
  input  logic              ld_lock_in,
  input  logic [ADDR_W-1:0] ld_addr_in,
  input  logic [DATA_W-1:0] ld_wdata_in,
  output logic              ld_gnt_out,
  input  logic              core_req_in,
  input  logic              core_we_in,
  input  logic [ADDR_W-1:0] core_addr_in,
  input  logic [DATA_W-1:0] core_wdata_in,
  output logic              core_gnt_out,
  output logic [DATA_W-1:0] core_rdata_out,
  input  logic              disp_req_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  output logic              disp_gnt_out,
  output logic [DATA_W-1:0] disp_rdata_out,
  output logic              disp_rdata_valid_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              mem_wen_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic [1:0]        owner_out,
  output logic              lock_timeout_out
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_LD   = 2'b01,
    OWN_CORE = 2'b10,
    OWN_DISP = 2'b11
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
  logic              disp_valid_q, disp_valid_d;
  logic              ld_elig, core_elig, disp_elig;

  always_comb begin
    owner_d      = OWN_NONE;
    lock_cnt_d   = '0;
    timeout_d    = timeout_q;
    disp_rdata_d = disp_rdata_q;
    disp_valid_d = 1'b0;
    // The current owner is never eligible, which also excludes the loader on a lock break.
    ld_elig   = ld_req_in   && (owner_q != OWN_LD);
    core_elig = core_req_in && (owner_q != OWN_CORE);
    disp_elig = disp_req_in && (owner_q != OWN_DISP);

    if (owner_q == OWN_LD && ld_lock_in && lock_cnt_q < CNT_LAST) begin
      owner_d    = OWN_LD;
      lock_cnt_d = lock_cnt_q + 1'b1;
    end else begin
      if (owner_q == OWN_LD && ld_lock_in) begin
        timeout_d = 1'b1;
      end
      if (ld_elig) begin
        owner_d = OWN_LD;
      end else if (core_elig) begin
        owner_d = OWN_CORE;
      end else if (disp_elig) begin
        owner_d = OWN_DISP;
      end
    end

    if (owner_q == OWN_DISP) begin
      disp_rdata_d = mem_rdata_in;
      disp_valid_d = 1'b1;
    end
  end

  always_comb begin
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    case (owner_q)
      OWN_LD: begin
        mem_addr_out  = ld_addr_in;
        mem_wdata_out = ld_wdata_in;
      end
      OWN_CORE: begin
        mem_addr_out  = core_addr_in;
        mem_wdata_out = core_wdata_in;
      end
      OWN_DISP: mem_addr_out = disp_addr_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      lock_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      disp_rdata_q <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      timeout_q    <= timeout_d;
      disp_rdata_q <= disp_rdata_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign ld_gnt_out           = (owner_q == OWN_LD);
  assign core_gnt_out         = (owner_q == OWN_CORE);
  assign disp_gnt_out         = (owner_q == OWN_DISP);
  // Reset gates the write strobe immediately, even mid-grant.
  assign mem_wen_out          = rst_n & ((ld_gnt_out & ld_req_in) |
                                         (core_gnt_out & core_req_in & core_we_in));
  assign core_rdata_out       = core_gnt_out ? mem_rdata_in : '0;
  assign disp_rdata_out       = disp_rdata_q;
  assign disp_rdata_valid_out = disp_valid_q;
  assign owner_out            = owner_q;
  assign lock_timeout_out     = timeout_q;

endmodule
